// File: rtl/reference_reader_pkg.sv
// Shared definitions for reference_reader and its skid FIFO.
//   state_e        : sequencer states (IDLE / RUN / DRAIN)
//   FIFO_DEPTH     : skid FIFO entries; also the request credit limit
//   FIFO_CNT_BITS  : width of the FIFO occupancy count (0..FIFO_DEPTH)
package reference_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned FIFO_DEPTH    = 2;
    localparam int unsigned FIFO_CNT_BITS = 2;

endpackage

// File: rtl/reference_reader_sample_fifo.sv
// 2-entry first-word-fall-through FIFO holding {I, Q, tlast} samples.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data (accepted when not full, or full with pop)
//   pop        : read request (ignored when empty)
//   rdata      : head entry, valid whenever count != 0
//   count      : current occupancy 0..FIFO_DEPTH
module reference_reader_sample_fifo
    import reference_reader_pkg::*;
#(
    parameter int unsigned width = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [width-1:0]         wdata,
    input  logic                     pop,
    output logic [width-1:0]         rdata,
    output logic [FIFO_CNT_BITS-1:0] count
);

    logic [width-1:0]         mem_q [FIFO_DEPTH];
    logic [width-1:0]         mem_d [FIFO_DEPTH];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_BITS-1:0] count_q, count_d;
    logic                     do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        // A full FIFO still takes a write when the head leaves in the same cycle.
        do_push = push && ((count_q != FIFO_CNT_BITS'(FIFO_DEPTH)) || do_pop);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + FIFO_CNT_BITS'(do_push) - FIFO_CNT_BITS'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/reference_reader.sv
// Sequencer upstream of reference_buffer: issues buffer_length read addresses
// starting at `shift` (wrapping at buffer_length), captures returned I/Q one
// cycle after each request and streams them as one AXI-Stream pass with tlast
// on the final beat. A 2-entry skid FIFO plus request credits absorbs the
// buffer's read latency under downstream back-pressure.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, shift          : begin a pass at index `shift` (sampled in IDLE)
//   busy, done, err       : pass active / 1-cycle completion / 1-cycle bad-shift reject
//   ref_rvalid, ref_raddr : read request to buffer
//   ref_rready            : held high from the first clock after reset
//   ref_svalid, ref_i/q   : buffer read data (svalid is sticky, qualified by our own request)
//   m_axis_*              : output sample stream
// Build option: REF_READER_CONJ_EN - emit the conjugate (Q negated, most
// negative Q saturated to the most positive value), applied at FIFO push.
module reference_reader
    import reference_reader_pkg::*;
#(
    parameter int unsigned buffer_length = 10,
    parameter int unsigned index_bits    = 4,
    parameter int unsigned i_bits        = 12,
    parameter int unsigned q_bits        = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [index_bits-1:0]    shift,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     ref_rvalid,
    output logic [index_bits-1:0]    ref_raddr,
    output logic                     ref_rready,
    input  logic                     ref_svalid,
    input  logic signed [i_bits-1:0] ref_i,
    input  logic signed [q_bits-1:0] ref_q,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic signed [i_bits-1:0] m_axis_i,
    output logic signed [q_bits-1:0] m_axis_q,
    output logic                     m_axis_tlast
);

    localparam int unsigned          WIDTH    = i_bits + q_bits + 1;
    localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);

    state_e                   state_q, state_d;
    logic [index_bits-1:0]    addr_q, addr_d;
    logic [index_bits-1:0]    issued_q, issued_d;   // requests issued this pass
    logic [index_bits-1:0]    beat_q, beat_d;       // samples pushed this pass
    logic                     inflight_q, inflight_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     rready_q, rready_d;

    logic                     req;
    logic                     push;
    logic                     pop;
    logic [2:0]               slots;
    logic signed [q_bits-1:0] q_push;
    logic [WIDTH-1:0]         fifo_wdata;
    logic [WIDTH-1:0]         fifo_rdata;
    logic [FIFO_CNT_BITS-1:0] fifo_count;
    logic                     head_tlast;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rready_q   <= rready_d;
        end
    end

    // Next-state
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        beat_d     = push ? beat_q + 1'b1 : beat_q;
        inflight_d = req;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rready_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(shift) < buffer_length) begin
                        state_d  = RUN;
                        addr_d   = shift;
                        issued_d = '0;
                        beat_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (req) begin
                    issued_d = issued_q + 1'b1;
                    addr_d   = (addr_q == LAST_IDX) ? '0 : addr_q + 1'b1;
                    if (issued_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath control
    always_comb begin
        pop   = m_axis_tvalid && m_axis_tready;
        // A pop this cycle frees a slot, which keeps the stream at full rate.
        slots = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        req   = (state_q == RUN) && (slots < 3'(FIFO_DEPTH));
        push  = inflight_q && ref_svalid;
`ifdef REF_READER_CONJ_EN
        if (ref_q == {1'b1, {(q_bits-1){1'b0}}}) begin
            q_push = {1'b0, {(q_bits-1){1'b1}}};
        end else begin
            q_push = -ref_q;
        end
`else
        q_push = ref_q;
`endif
        fifo_wdata = {ref_i, q_push, (beat_q == LAST_IDX)};
    end

    reference_reader_sample_fifo #(
        .width (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign {m_axis_i, m_axis_q, head_tlast} = fifo_rdata;
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tlast  = head_tlast && m_axis_tvalid;
    assign ref_rvalid    = req;
    assign ref_raddr     = addr_q;
    assign ref_rready    = rready_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_reference_reader.sv
// Self-checking bench for reference_reader with a 1-cycle-latency buffer model.
module tb_reference_reader;

    localparam int LEN = 10;
    localparam int IB  = 4;
    localparam int IW  = 12;
    localparam int QW  = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [IB-1:0]        shift;
    logic                 busy, done, err;
    logic                 ref_rvalid;
    logic [IB-1:0]        ref_raddr;
    logic                 ref_rready;
    logic                 ref_svalid = 1'b0;
    logic signed [IW-1:0] ref_i = '0;
    logic signed [QW-1:0] ref_q = '0;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic signed [IW-1:0] m_axis_i;
    logic signed [QW-1:0] m_axis_q;
    logic                 m_axis_tlast;

    logic signed [IW-1:0] mem_i [LEN];
    logic signed [QW-1:0] mem_q [LEN];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int i;
        int q;
        int last;
    } beat_t;

    always #5 clk = ~clk;

    reference_reader #(
        .buffer_length (LEN),
        .index_bits    (IB),
        .i_bits        (IW),
        .q_bits        (QW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .shift         (shift),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .ref_rvalid    (ref_rvalid),
        .ref_raddr     (ref_raddr),
        .ref_rready    (ref_rready),
        .ref_svalid    (ref_svalid),
        .ref_i         (ref_i),
        .ref_q         (ref_q),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_i      (m_axis_i),
        .m_axis_q      (m_axis_q),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Buffer model: data appears the cycle after a request; valid is sticky.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_svalid <= 1'b0;
        end else if (ref_rvalid && ref_rready) begin
            ref_svalid <= 1'b1;
            if (int'(ref_raddr) < LEN) begin
                ref_i <= mem_i[ref_raddr];
                ref_q <= mem_q[ref_raddr];
            end else begin
                ref_i <= '0;
                ref_q <= '0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_q(input int k);
        int v;
        v = int'(mem_q[k]);
`ifdef REF_READER_CONJ_EN
        v = -v;
        if (v > (1 << (QW - 1)) - 1) v = (1 << (QW - 1)) - 1;
`endif
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_done"},   int'(done), 0);
        chk({tag, "_err"},    int'(err), 0);
        chk({tag, "_rvalid"}, int'(ref_rvalid), 0);
        chk({tag, "_raddr"},  int'(ref_raddr), 0);
        chk({tag, "_rready"}, int'(ref_rready), 0);
        chk({tag, "_tvalid"}, int'(m_axis_tvalid), 0);
        chk({tag, "_tlast"},  int'(m_axis_tlast), 0);
    endtask

    // One pass. rand_ready: 50% tready; inject_at: cycle to pulse a (to be
    // ignored) start; abort_beat > 0: assert reset after that many beats.
    task automatic run_pass(input int sh, input bit rand_ready, input int inject_at,
                            input int abort_beat);
        beat_t expq[$];
        int    exp_addr[$];
        int    cyc, beats, reqs, dones, first_cyc, last_hs;
        bit    aborted;
        cyc = 0; beats = 0; reqs = 0; dones = 0; first_cyc = -1; last_hs = -100;
        aborted = 1'b0;
        for (int b = 0; b < LEN; b++) begin
            beat_t e;
            int    k;
            k      = (sh + b) % LEN;
            e.i    = int'(mem_i[k]);
            e.q    = model_q(k);
            e.last = (b == LEN - 1) ? 1 : 0;
            expq.push_back(e);
            exp_addr.push_back(k);
        end

        shift = IB'(sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);

        while (dones == 0 && cyc < 200) begin
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == inject_at) begin
                start = 1'b1;
                shift = IB'((sh + 5) % LEN);
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                dones++;
                chk("done_timing", last_hs, cyc - 1);
                chk("done_all_beats", expq.size(), 0);
            end
            if (ref_rvalid) begin
                reqs++;
                if (exp_addr.size() > 0) chk("raddr", int'(ref_raddr), exp_addr.pop_front());
                else chk("extra_request", reqs, LEN);
            end
            if (m_axis_tvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (expq.size() == 0) begin
                    chk("extra_beat", beats + 1, LEN);
                end else begin
                    chk("beat_i", int'(m_axis_i), expq[0].i);
                    chk("beat_q", int'(m_axis_q), expq[0].q);
                    chk("beat_tlast", int'(m_axis_tlast), expq[0].last);
                end
                if (m_axis_tready) begin
                    if (expq.size() > 0) void'(expq.pop_front());
                    beats++;
                    last_hs = cyc;
                end
            end
            chk("outstanding_le_2", int'((reqs - beats) <= 2), 1);
            if (abort_beat > 0 && beats == abort_beat) begin
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        if (aborted) begin
            rst_n = 1'b0;
            #1;
            check_reset_values("abort");
            @(posedge clk); #1;
            chk("abort_no_done", int'(done), 0);
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk("abort_rready", int'(ref_rready), 1);
            chk("abort_idle", int'(busy), 0);
        end else begin
            chk("done_seen", dones, 1);
            chk("beat_count", beats, LEN);
            chk("request_count", reqs, LEN);
            chk("first_beat_latency", int'(first_cyc >= 2), 1);
            if (!rand_ready) chk("full_rate", last_hs - first_cyc, LEN - 1);
            chk("busy_at_done", int'(busy), 0);
            @(posedge clk); #1;
            chk("done_pulse", int'(done), 0);
        end
    endtask

    initial begin
        for (int k = 0; k < LEN; k++) begin
            mem_i[k] = IW'(k);
            mem_q[k] = QW'(-k);
        end
        rst_n = 1'b0;
        start = 1'b0;
        shift = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rready_after_reset", int'(ref_rready), 1);

        run_pass(0, 1'b0, -1, -1);
        run_pass(7, 1'b0, -1, -1);
        run_pass(3, 1'b1, 4, -1);

        // Out-of-range shift is rejected
        shift = IB'(12);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_rvalid", int'(ref_rvalid), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("err_cleared", int'(err), 0);
            chk("err_idle_busy", int'(busy), 0);
            chk("err_idle_rvalid", int'(ref_rvalid), 0);
        end

        run_pass(2, 1'b1, -1, 4);
        run_pass(0, 1'b0, -1, -1);

        // Random contents, including the Q values around the conjugate corner
        for (int k = 0; k < LEN; k++) begin
            mem_i[k] = IW'($urandom);
            mem_q[k] = QW'($urandom);
        end
        mem_q[5] = QW'(-2048);
        mem_q[6] = QW'(5);
        for (int p = 0; p < 6; p++) begin
            run_pass(int'($urandom_range(0, LEN - 1)), 1'($urandom_range(0, 1)), -1, -1);
        end
        run_pass(9, 1'b1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
